// File: rtl/maze_run_if.sv
// Host-side handshake bundle for maze_run_controller: run request, result handshake and results.
// With MAZE_RUN_STATS_EN defined the bundle also carries run_count and best_cycles.
interface maze_run_if #(
    parameter int size = 9,
    parameter int N    = 3,
    parameter int CW   = 16
);
    localparam int VW = $clog2(size * size + 1);

    logic          start;
    logic          busy;
    logic          result_valid;
    logic          result_ack;
    logic [CW-1:0] cycles;
    logic          timeout;
    logic [N-1:0]  end_x;
    logic [N-1:0]  end_y;
    logic [VW-1:0] visited;
`ifdef MAZE_RUN_STATS_EN
    logic [CW-1:0] run_count;
    logic [CW-1:0] best_cycles;
`endif

    modport master (
        output start,
        output result_ack,
        input  busy,
        input  result_valid,
        input  cycles,
        input  timeout,
        input  end_x,
        input  end_y,
`ifdef MAZE_RUN_STATS_EN
        input  run_count,
        input  best_cycles,
`endif
        input  visited
    );

    modport slave (
        input  start,
        input  result_ack,
        output busy,
        output result_valid,
        output cycles,
        output timeout,
        output end_x,
        output end_y,
`ifdef MAZE_RUN_STATS_EN
        output run_count,
        output best_cycles,
`endif
        output visited
    );
endinterface

// File: rtl/maze_run_controller.sv
// Sequences a single escaper run: reset pulse, timed RUN with timeout, row-by-row path pop-count, host report.
// Optional run statistics (run_count, best_cycles) are built only when MAZE_RUN_STATS_EN is defined.
module maze_run_controller #(
    parameter int size       = 9,
    parameter int N          = 3,
    parameter int CW         = 16,
    parameter int TIMEOUT    = 4096,
    parameter int RST_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 esc_rst,
    input  logic                 esc_done,
    input  logic [N-1:0]         esc_x,
    input  logic [N-1:0]         esc_y,
    input  logic [size*size-1:0] esc_path,
    maze_run_if.slave            host
);

    localparam int VW  = $clog2(size * size + 1);
    localparam int RW  = (size > 1) ? $clog2(size) : 1;
    localparam int RCW = $clog2(RST_CYCLES + 1);

    localparam logic [CW-1:0]  TIMEOUT_C  = CW'(TIMEOUT);
    localparam logic [CW-1:0]  CYC_MAX_C  = {CW{1'b1}};
    localparam logic [RW-1:0]  LAST_ROW_C = RW'(size - 1);
    localparam logic [RCW-1:0] LAST_RST_C = RCW'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET_DUT = 3'd1,
        ST_RUN       = 3'd2,
        ST_COUNT     = 3'd3,
        ST_REPORT    = 3'd4
    } state_t;

    state_t         state_r;
    logic [RCW-1:0] rst_cnt_r;
    logic [RW-1:0]  row_r;
    logic [CW-1:0]  cyc_inc_s;
    logic [size-1:0] row_bits_s;

    // Number of set cells in one maze row.
    function automatic logic [VW-1:0] row_pop(input logic [size-1:0] r);
        logic [VW-1:0] c;
        c = {VW{1'b0}};
        for (int i = 0; i < size; i++) begin
            c = c + {{(VW-1){1'b0}}, r[i]};
        end
        return c;
    endfunction

    // Saturating next cycle count and the path row currently being counted.
    always_comb begin
        cyc_inc_s  = (host.cycles == CYC_MAX_C) ? host.cycles : host.cycles + {{(CW-1){1'b0}}, 1'b1};
        row_bits_s = {size{1'b0}};
        if (int'(row_r) < size) begin
            row_bits_s = esc_path[int'(row_r)*size +: size];
        end else begin
            row_bits_s = {size{1'b0}};
        end
    end

    // Run sequencer with all host and escaper outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r           <= ST_IDLE;
            rst_cnt_r         <= {RCW{1'b0}};
            row_r             <= {RW{1'b0}};
            esc_rst           <= 1'b1;
            host.busy         <= 1'b0;
            host.result_valid <= 1'b0;
            host.cycles       <= {CW{1'b0}};
            host.timeout      <= 1'b0;
            host.end_x        <= {N{1'b0}};
            host.end_y        <= {N{1'b0}};
            host.visited      <= {VW{1'b0}};
`ifdef MAZE_RUN_STATS_EN
            host.run_count    <= {CW{1'b0}};
            host.best_cycles  <= {CW{1'b1}};
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    esc_rst <= 1'b0;
                    if (host.start) begin
                        state_r      <= ST_RESET_DUT;
                        esc_rst      <= 1'b1;
                        host.busy    <= 1'b1;
                        host.cycles  <= {CW{1'b0}};
                        host.timeout <= 1'b0;
                        host.visited <= {VW{1'b0}};
                        rst_cnt_r    <= {RCW{1'b0}};
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RESET_DUT: begin
                    if (rst_cnt_r == LAST_RST_C) begin
                        state_r <= ST_RUN;
                        esc_rst <= 1'b0;
                    end else begin
                        rst_cnt_r <= rst_cnt_r + {{(RCW-1){1'b0}}, 1'b1};
                        esc_rst   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    host.cycles <= cyc_inc_s;
                    // Done has priority, so a coincident timeout is not flagged.
                    if (esc_done) begin
                        host.end_x <= esc_x;
                        host.end_y <= esc_y;
                        row_r      <= {RW{1'b0}};
                        state_r    <= ST_COUNT;
                    end else if (cyc_inc_s == TIMEOUT_C) begin
                        host.timeout <= 1'b1;
                        host.end_x   <= esc_x;
                        host.end_y   <= esc_y;
                        row_r        <= {RW{1'b0}};
                        state_r      <= ST_COUNT;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_COUNT: begin
                    host.visited <= host.visited + row_pop(row_bits_s);
                    if (row_r == LAST_ROW_C) begin
                        state_r           <= ST_REPORT;
                        host.result_valid <= 1'b1;
                    end else begin
                        row_r <= row_r + {{(RW-1){1'b0}}, 1'b1};
                    end
                end
                ST_REPORT: begin
                    if (host.result_ack) begin
                        state_r           <= ST_IDLE;
                        host.result_valid <= 1'b0;
                        host.busy         <= 1'b0;
`ifdef MAZE_RUN_STATS_EN
                        if (host.run_count != {CW{1'b1}}) begin
                            host.run_count <= host.run_count + {{(CW-1){1'b0}}, 1'b1};
                        end else begin
                            host.run_count <= host.run_count;
                        end
                        if (!host.timeout && (host.cycles < host.best_cycles)) begin
                            host.best_cycles <= host.cycles;
                        end else begin
                            host.best_cycles <= host.best_cycles;
                        end
`endif
                    end else begin
                        state_r <= ST_REPORT;
                    end
                end
                default: begin
                    state_r           <= ST_IDLE;
                    esc_rst           <= 1'b0;
                    host.busy         <= 1'b0;
                    host.result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maze_run_controller.sv
// Randomized self-checking bench for maze_run_controller with a stub escaper and a rule-level result model.
module tb_maze_run_controller;

    localparam int SIZE = 9;
    localparam int NB   = 4;
    localparam int CW   = 16;
    localparam int TO   = 100;
    localparam int RC   = 2;

    logic                 clk;
    logic                 rst;
    logic                 esc_rst;
    logic                 esc_done;
    logic [NB-1:0]        esc_x;
    logic [NB-1:0]        esc_y;
    logic [SIZE*SIZE-1:0] esc_path;

    maze_run_if #(.size(SIZE), .N(NB), .CW(CW)) mif ();

    maze_run_controller #(
        .size(SIZE), .N(NB), .CW(CW), .TIMEOUT(TO), .RST_CYCLES(RC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .esc_rst  (esc_rst),
        .esc_done (esc_done),
        .esc_x    (esc_x),
        .esc_y    (esc_y),
        .esc_path (esc_path),
        .host     (mif.slave)
    );

    int checks_n;
    int fail_n;

    // Stub escaper: counts cycles out of reset, raises done after d_target cycles.
    int           stub_cnt;
    int           d_target;
    logic [NB-1:0] xb;
    logic [NB-1:0] yb;
    logic          xs;

    always @(posedge clk) begin
        if (esc_rst) stub_cnt <= 0;
        else         stub_cnt <= stub_cnt + 1;
    end

    assign esc_done = !esc_rst && (stub_cnt >= d_target - 1);
    assign esc_x    = xs ? NB'(xb + stub_cnt[NB-1:0]) : xb;
    assign esc_y    = xs ? NB'(yb - stub_cnt[NB-1:0]) : yb;

    int run_count_m;
    int best_m;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_n++;
        if (got !== exp) begin
            fail_n++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One complete run against the model: expected cycles/timeout from the done delay, visited by popcount.
    task automatic do_run(input int d, input logic [SIZE*SIZE-1:0] path, input logic [NB-1:0] x0,
                          input logic [NB-1:0] y0, input logic step, input int ackdly, input bit start_in_report);
        int lat;
        int cyc_e;
        int to_e;
        int xe;
        int ye;
        d_target = d;
        esc_path = path;
        xb = x0;
        yb = y0;
        xs = step;
        cyc_e = (d <= TO) ? d : TO;
        to_e  = (d > TO) ? 1 : 0;
        xe = step ? ((int'(x0) + cyc_e - 1) & 15) : int'(x0);
        ye = step ? ((int'(y0) - cyc_e + 1) & 15) : int'(y0);
        mif.start = 1'b1;
        @(negedge clk);
        mif.start = 1'b0;
        lat = 1;
        check_eq("busy_after_start", mif.busy, 1);
        check_eq("esc_rst_pulse", esc_rst, 1);
        while (!mif.result_valid && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        check_eq("latency", lat, 1 + RC + cyc_e + SIZE);
        check_eq("cycles", mif.cycles, cyc_e);
        check_eq("timeout", mif.timeout, to_e);
        check_eq("end_x", mif.end_x, xe);
        check_eq("end_y", mif.end_y, ye);
        check_eq("visited", mif.visited, $countones(path));
        check_eq("busy_report", mif.busy, 1);
        repeat (ackdly) @(negedge clk);
        check_eq("valid_held", mif.result_valid, 1);
        if (start_in_report) begin
            mif.start = 1'b1;
            @(negedge clk);
            mif.start = 1'b0;
            check_eq("valid_after_start", mif.result_valid, 1);
        end
        mif.result_ack = 1'b1;
        @(negedge clk);
        mif.result_ack = 1'b0;
        check_eq("valid_after_ack", mif.result_valid, 0);
        check_eq("busy_after_ack", mif.busy, 0);
        run_count_m++;
        if (!to_e && cyc_e < best_m) best_m = cyc_e;
        @(negedge clk);
        check_eq("idle_stays", mif.busy, 0);
        check_eq("cycles_hold", mif.cycles, cyc_e);
`ifdef MAZE_RUN_STATS_EN
        check_eq("run_count", mif.run_count, run_count_m);
        check_eq("best_cycles", mif.best_cycles, best_m);
`endif
    endtask

    initial begin
        logic [SIZE*SIZE-1:0] p;
        int lat;
        checks_n = 0;
        fail_n = 0;
        run_count_m = 0;
        best_m = 65535;
        d_target = 1000000;
        xb = '0;
        yb = '0;
        xs = 1'b0;
        esc_path = '0;
        mif.start = 1'b0;
        mif.result_ack = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_esc_rst", esc_rst, 1);
        check_eq("rst_busy", mif.busy, 0);
        check_eq("rst_valid", mif.result_valid, 0);
        check_eq("rst_cycles", mif.cycles, 0);
        check_eq("rst_visited", mif.visited, 0);
        check_eq("rst_timeout", mif.timeout, 0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("idle_esc_rst", esc_rst, 0);

        p = '0;
        p[8:0]   = 9'h010;
        p[80:72] = 9'h010;
        do_run(50, p, 4'd4, 4'd8, 1'b0, 0, 1'b0);
        p = SIZE*SIZE'({$urandom(), $urandom(), $urandom()});
        do_run(30, p, 4'($urandom), 4'($urandom), 1'b1, 20, 1'b1);
        p = SIZE*SIZE'({$urandom(), $urandom(), $urandom()});
        do_run(1000000, p, 4'($urandom), 4'($urandom), 1'b1, 1, 1'b0);
        p = SIZE*SIZE'({$urandom(), $urandom(), $urandom()});
        do_run(TO, p, 4'($urandom), 4'($urandom), 1'b1, 0, 1'b0);

        // Reset in the middle of RUN.
        d_target = 1000000;
        mif.start = 1'b1;
        @(negedge clk);
        mif.start = 1'b0;
        lat = 1;
        while (lat < 1 + RC + 30) begin
            @(negedge clk);
            lat++;
        end
        check_eq("mid_cycles", mif.cycles, 30);
        rst = 1'b0;
        #1;
        check_eq("mid_esc_rst", esc_rst, 1);
        check_eq("mid_busy", mif.busy, 0);
        check_eq("mid_valid", mif.result_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("mid_no_result", mif.result_valid, 0);
`ifdef MAZE_RUN_STATS_EN
        run_count_m = 0;
        best_m = 65535;
`endif

        for (int i = 0; i < 8; i++) begin
            p = SIZE*SIZE'({$urandom(), $urandom(), $urandom()});
            do_run($urandom_range(1, 130), p, 4'($urandom), 4'($urandom), 1'($urandom),
                   $urandom_range(0, 5), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_n, fail_n);
        $finish;
    end

endmodule
